// File: rtl/max_finder_win.sv
// max_finder_win: windowed per-frame peak finder with threshold hit counting.
// Optional MAX_FINDER_EDGE_EN adds first/last threshold-crossing positions.
module max_finder_win #(
    parameter int DATA_W = 10,
    parameter int POS_W  = 9,
    parameter int WIN_LO = 8,
    parameter int WIN_HI = 2**POS_W - 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              start,
    input  logic              frame_end,
    input  logic              data_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic [POS_W-1:0]  data_pos,
    input  logic [DATA_W-1:0] thr_in,
    output logic [DATA_W-1:0] max_value,
    output logic [POS_W-1:0]  max_pos,
    output logic [POS_W:0]    hit_count,
    output logic              found,
    output logic              result_valid,
    output logic              busy
`ifdef MAX_FINDER_EDGE_EN
    ,
    output logic [POS_W-1:0]  edge_first,
    output logic [POS_W-1:0]  edge_last
`endif
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    state_t state;
    logic accept, load, hit;
    logic [DATA_W-1:0] max_next;
    always_comb begin
        accept = state == SCAN && data_valid && !start &&
                 {1'b0, data_pos} >= (POS_W+1)'(WIN_LO) &&
                 {1'b0, data_pos} <= (POS_W+1)'(WIN_HI);
        load = accept && data_in > max_value;
        hit = accept && data_in >= thr_in;
        max_next = load ? data_in : max_value;
    end
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || start) begin
            state <= rst_n_in ? SCAN : IDLE;
            busy <= rst_n_in;
            result_valid <= 1'b0;
            max_value <= '0;
            max_pos <= '0;
            hit_count <= '0;
            found <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (load) begin
                max_value <= data_in;
                max_pos <= data_pos;
            end
            if (hit)
                hit_count <= hit_count + (POS_W+1)'(hit_count != '1);
            // found uses the peak including the frame_end sample itself
            if (state == SCAN && frame_end) begin
                state <= DONE;
                busy <= 1'b0;
                result_valid <= 1'b1;
                found <= max_next >= thr_in;
            end else if (state == DONE) begin
                state <= IDLE;
            end
        end
    end
`ifdef MAX_FINDER_EDGE_EN
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || start) begin
            edge_first <= '0;
            edge_last <= '0;
        end else if (hit) begin
            edge_last <= data_pos;
            if (hit_count == '0)
                edge_first <= data_pos;
        end
    end
`endif
endmodule
